// File: rtl/cmp_pkg.sv
// Shared types for the chunked sequential comparator.
//   cmp_state_t : FSM encoding (IDLE, CMP, DONE)
//   cmp_res_t   : packed {g, e, l} result triple
//   RES_*       : canonical result encodings
package cmp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } cmp_state_t;

  typedef struct packed {
    logic g;
    logic e;
    logic l;
  } cmp_res_t;

  localparam cmp_res_t RES_NONE = 3'b000;
  localparam cmp_res_t RES_GT   = 3'b100;
  localparam cmp_res_t RES_EQ   = 3'b010;
  localparam cmp_res_t RES_LT   = 3'b001;

endpackage

// File: rtl/chunk_cmp.sv
// Combinational magnitude compare of one CHUNK-bit slice.
//   ca, cb     : chunk of operand A / B
//   invert_msb : flip the MSB of both chunks first (offset-binary view of a
//                two's-complement top chunk)
//   gt, lt     : ca > cb, ca < cb after the optional MSB flip
module chunk_cmp #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] ca,
  input  logic [CHUNK-1:0] cb,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt
);

  logic [CHUNK-1:0] ca_x;
  logic [CHUNK-1:0] cb_x;

  always_comb begin
    ca_x            = ca;
    cb_x            = cb;
    ca_x[CHUNK-1]   = ca[CHUNK-1] ^ invert_msb;
    cb_x[CHUNK-1]   = cb[CHUNK-1] ^ invert_msb;
    gt              = ca_x > cb_x;
    lt              = ca_x < cb_x;
  end

endmodule

// File: rtl/chunk_seq_comparator.sv
// Multi-cycle WIDTH-bit magnitude comparator. Walks the operands MSB-first,
// CHUNK bits per cycle, and stops at the first differing chunk.
//   clk, rst     : rising-edge clock, async active-high reset
//   start        : request, accepted in IDLE or DONE
//   signed_mode  : 1 = two's-complement compare (sampled with start)
//   a, b         : operands (sampled with start)
//   busy         : compare in progress (state CMP)
//   done         : one-cycle pulse, result valid (state DONE)
//   g, e, l      : registered a>b / a==b / a<b, held until the next start
module chunk_seq_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             e,
  output logic             l
);

  // WIDTH must be a multiple of CHUNK.
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  cmp_state_t       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sm_q, sm_d;
  cmp_res_t         res_q, res_d;

  logic [CHUNK-1:0] ca, cb;
  logic             invert_msb;
  logic             gt, lt;

  // Select the active chunk with constant slices so the mux stays a plain
  // one-hot-decoded structure.
  always_comb begin
    ca = '0;
    cb = '0;
    for (int i = 0; i < NCHUNK; i++) begin
      if (idx_q == IDXW'(i)) begin
        ca = a_q[i*CHUNK +: CHUNK];
        cb = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  // Only the top chunk carries the sign bit.
  assign invert_msb = sm_q && (idx_q == IDXW'(NCHUNK-1));

  chunk_cmp #(.CHUNK(CHUNK)) u_chunk_cmp (
    .ca         (ca),
    .cb         (cb),
    .invert_msb (invert_msb),
    .gt         (gt),
    .lt         (lt)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sm_d    = sm_q;
    res_d   = res_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          sm_d    = signed_mode;
          idx_d   = IDXW'(NCHUNK-1);
          res_d   = RES_NONE;
          state_d = CMP;
        end else begin
          state_d = IDLE;
        end
      end
      CMP: begin
        if (gt) begin
          res_d   = RES_GT;
          state_d = DONE;
        end else if (lt) begin
          res_d   = RES_LT;
          state_d = DONE;
        end else if (idx_q == '0) begin
          res_d   = RES_EQ;
          state_d = DONE;
        end else begin
          idx_d   = idx_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sm_q    <= 1'b0;
      res_q   <= RES_NONE;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sm_q    <= sm_d;
      res_q   <= res_d;
    end
  end

  assign busy = (state_q == CMP);
  assign done = (state_q == DONE);
  assign g    = res_q.g;
  assign e    = res_q.e;
  assign l    = res_q.l;

endmodule

// File: tb/tb_chunk_seq_comparator.sv
module tb_chunk_seq_comparator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        st4 = 1'b0;
  logic        st16 = 1'b0;
  logic        sm = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        busy4, done4, g4, e4, l4;
  logic        busy16, done16, g16, e16, l16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  chunk_seq_comparator #(.WIDTH(16), .CHUNK(4)) dut4 (
    .clk(clk), .rst(rst), .start(st4), .signed_mode(sm), .a(a), .b(b),
    .busy(busy4), .done(done4), .g(g4), .e(e4), .l(l4)
  );

  chunk_seq_comparator #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst(rst), .start(st16), .signed_mode(sm), .a(a), .b(b),
    .busy(busy16), .done(done16), .g(g16), .e(e16), .l(l16)
  );

  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sm;
    logic [2:0]  res;
    int          k;
  } vec_t;

  vec_t vecs[10];

  // {busy, done, g, e, l} of the selected instance
  function automatic logic [4:0] outs(input bit w);
    return w ? {busy16, done16, g16, e16, l16} : {busy4, done4, g4, e4, l4};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Starts one compare, counts CMP cycles, leaves time in the DONE cycle.
  task automatic run_cmp(input bit w, input logic [15:0] va, input logic [15:0] vb,
                         input logic vsm, input logic [2:0] eres, input int ek,
                         input string nm);
    logic [4:0] o;
    int k;
    a = va; b = vb; sm = vsm;
    if (w) st16 = 1'b1; else st4 = 1'b1;
    tick();
    st4 = 1'b0; st16 = 1'b0;
    o = outs(w);
    chk({nm, "_accept"}, {27'd0, o}, {27'd0, 5'b10000});
    k = 0;
    while (outs(w)[4] && k < 40) begin
      k++;
      tick();
    end
    o = outs(w);
    chk({nm, "_cycles"}, k, ek);
    chk({nm, "_done"}, {31'd0, o[3]}, 32'd1);
    chk({nm, "_res"}, {29'd0, o[2:0]}, {29'd0, eres});
  endtask

  initial begin
    logic [4:0] o;
    int k;
    bit saw_done;
    logic [2:0] er;

    vecs[0] = '{16'h1234, 16'h1234, 1'b0, EQ, 4};
    vecs[1] = '{16'h8000, 16'h7FFF, 1'b0, GT, 1};
    vecs[2] = '{16'h8000, 16'h7FFF, 1'b1, LT, 1};
    vecs[3] = '{16'h12F0, 16'h1300, 1'b0, LT, 2};
    vecs[4] = '{16'hFFFF, 16'hFFFE, 1'b1, GT, 4};
    vecs[5] = '{16'h7FFF, 16'h8000, 1'b1, GT, 1};
    vecs[6] = '{16'hFFFF, 16'h0001, 1'b1, LT, 1};
    vecs[7] = '{16'h0000, 16'h0000, 1'b1, EQ, 4};
    vecs[8] = '{16'hABCD, 16'hABCE, 1'b0, LT, 4};
    vecs[9] = '{16'hA000, 16'h9FFF, 1'b1, GT, 1};

    // Reset state
    #1;
    chk("reset_outs4", {27'd0, outs(1'b0)}, 32'd0);
    chk("reset_outs16", {27'd0, outs(1'b1)}, 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_outs4", {27'd0, outs(1'b0)}, 32'd0);

    // Table vectors, each followed by a return to IDLE with the result held
    for (int i = 0; i < 10; i++) begin
      run_cmp(1'b0, vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].res, vecs[i].k,
              $sformatf("vec%0d", i));
      tick();
      o = outs(1'b0);
      chk($sformatf("vec%0d_held", i), {27'd0, o}, {27'd0, 2'b00, vecs[i].res});
    end
    tick(); tick();
    chk("held_idle", {27'd0, outs(1'b0)}, {27'd0, 2'b00, GT});

    // start re-pulsed during CMP is ignored
    a = 16'h1234; b = 16'h1235; sm = 1'b0; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    k = 0;
    while (busy4 && k < 40) begin
      k++;
      if (k == 2) begin st4 = 1'b1; a = '0; b = '0; end
      else st4 = 1'b0;
      tick();
    end
    st4 = 1'b0;
    chk("ignore_cycles", k, 4);
    chk("ignore_res", {29'd0, g4, e4, l4}, {29'd0, LT});
    chk("ignore_done", {31'd0, done4}, 32'd1);

    // Back-to-back start in the DONE cycle
    a = 16'h0002; b = 16'h0001; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    chk("b2b_accept", {27'd0, outs(1'b0)}, {27'd0, 5'b10000});
    k = 0;
    while (busy4 && k < 40) begin k++; tick(); end
    chk("b2b_cycles", k, 4);
    chk("b2b_res", {27'd0, outs(1'b0)}, {27'd0, 2'b01, GT});
    tick();
    chk("b2b_done_gone", {31'd0, done4}, 32'd0);

    // Reset mid-CMP: async clear, no done pulse afterwards
    a = 16'h1234; b = 16'h1234; st4 = 1'b1;
    tick();
    st4 = 1'b0;
    tick();
    chk("mid_busy", {31'd0, busy4}, 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst", {27'd0, outs(1'b0)}, 32'd0);
    tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (done4 || busy4) saw_done = 1'b1;
      tick();
    end
    chk("no_done_after_rst", {31'd0, saw_done}, 32'd0);
    run_cmp(1'b0, 16'd5, 16'd9, 1'b0, LT, 4, "post_rst");
    tick();

    // Full-width instance: single CMP cycle, random operands vs reference
    for (int i = 0; i < 200; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      rb = (i % 8 == 0) ? ra : 16'($urandom);
      if (i == 1) begin ra = 16'h8000; rb = 16'h7FFF; end
      if (i == 2) begin ra = 16'hFFFF; rb = 16'h0000; end
      rs = 1'($urandom_range(0, 1));
      if (rs) er = ($signed(ra) > $signed(rb)) ? GT : ($signed(ra) < $signed(rb)) ? LT : EQ;
      else    er = (ra > rb) ? GT : (ra < rb) ? LT : EQ;
      run_cmp(1'b1, ra, rb, rs, er, 1, $sformatf("w16_%0d", i));
      chk($sformatf("w16_%0d_onehot", i), $countones({g16, e16, l16}), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/chunk_seq_comparator.md
Name: chunk_seq_comparator

Overview:
- Parametrised, multi-cycle magnitude comparator. It is the successor of the team's 4-bit combinational g/e/l comparator.
- Compares two WIDTH-bit operands MSB-first, CHUNK bits per cycle, and terminates early at the first differing chunk.
- Supports unsigned and two's-complement signed modes.
- Uses a start/busy/done handshake; sits beside datapath blocks that need wide compares without a long combinational path.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits compared per cycle; 1 <= CHUNK <= WIDTH.
- NCHUNK, WIDTH/CHUNK, derived local constant; not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  request; accepted only in IDLE or DONE
- signed_mode  in  1  1 = two's-complement compare; sampled with start
- a  in  WIDTH  operand A; sampled with start
- b  in  WIDTH  operand B; sampled with start
- busy  out  1  high while state == CMP
- done  out  1  one-cycle pulse: result valid, state == DONE
- g  out  1  registered result a > b
- e  out  1  registered result a == b
- l  out  1  registered result a < b

Interface (already decided): one clock (clk); reset (rst) is asynchronous and active-high.

Behaviour:
- Reset (async, any state):
  - state = IDLE, chunk index = 0, captured operands = 0.
  - busy = done = g = e = l = 0.
- FSM states: IDLE, CMP, DONE.
- IDLE:
  - start = 1 captures a, b and signed_mode into internal registers.
  - Chunk index is set to NCHUNK-1; g, e and l are cleared to 0; next state is CMP.
  - start = 0: remain in IDLE.
- CMP, one chunk per cycle, chunk idx = bits [idx*CHUNK+CHUNK-1 : idx*CHUNK]:
  - Signed mode, top chunk only: invert the MSB of both chunks before comparing (offset-binary). All other chunks compare unsigned.
  - Chunk A > chunk B: g <= 1, go to DONE.
  - Chunk A < chunk B: l <= 1, go to DONE.
  - Equal and idx == 0: e <= 1, go to DONE.
  - Equal and idx > 0: idx <= idx-1, stay in CMP.
  - start is ignored; live a, b and signed_mode inputs are ignored.
- DONE:
  - done = 1 for exactly this cycle.
  - start = 1 is accepted exactly as in IDLE (back-to-back operation); otherwise next state is IDLE.
- Latency:
  - k = number of chunks examined, 1..NCHUNK.
  - With start sampled at edge 0, g/e/l update at edge k and done is high in the cycle following edge k.
  - Worst case is NCHUNK+1 cycles from start to the end of the done pulse.
- Result outputs:
  - After the first completed compare, exactly one of g/e/l is high.
  - Results are held through IDLE until the next accepted start clears them.
  - All three are 0 while a compare is in progress.
- Degenerate case CHUNK == WIDTH: always exactly one CMP cycle.
- Reset mid-CMP: the operation is aborted, no done pulse is produced, and the next start behaves normally.

Decomposition:
- Shared package (cmp_pkg):
  - state enum typedef {IDLE, CMP, DONE}.
  - Packed result struct {g, e, l}.
  - Result constants RES_NONE, RES_GT, RES_EQ and RES_LT.
- Sub-module chunk_cmp:
  - Parameter CHUNK; purely combinational.
  - Inputs: ca, cb, invert_msb.
  - Outputs: gt, lt.
  - Instantiated once; the FSM muxes the active chunk into it.

Test Plan:
1. WIDTH=16, CHUNK=4, unsigned, a=0x1234, b=0x1234 -> busy for 4 cycles, done pulse in cycle 5, e=1, g=l=0.
2. a=0x8000, b=0x7FFF, unsigned -> 1 CMP cycle, g=1. Repeat with signed_mode=1 -> l=1.
3. Unsigned a=0x12F0, b=0x1300 -> decided at chunk 2 after 2 CMP cycles, l=1. Then signed a=0xFFFF, b=0xFFFE -> 4 CMP cycles, g=1.
4. start re-pulsed during CMP with a=b=0 -> ignored, original result delivered. Then start held high in the DONE cycle with new operands -> accepted: busy=1 next cycle, g/e/l cleared.
5. rst asserted mid-CMP (cycle 2 of 4) -> busy, done, g, e and l go to 0 without waiting for a clock edge, and no done pulse follows. Release rst, start a=5, b=9 -> l=1 with normal latency.
6. CHUNK=16 instance, random 200 signed/unsigned pairs -> 1 CMP cycle each; g/e/l match a reference model and exactly one is high.
